// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: coin encodings, coin
// values, FSM states and a coin-to-value helper.
package change_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    CIRCLE   = 2'd1,
    TRIANGLE = 2'd2,
    PENTAGON = 2'd3
  } coin_t;

  localparam int unsigned CIR_VAL  = 1;
  localparam int unsigned TRI_VAL  = 3;
  localparam int unsigned PENT_VAL = 5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  function automatic int unsigned coin_value(input coin_t c);
    int unsigned v;
    unique case (c)
      PENTAGON: v = PENT_VAL;
      TRIANGLE: v = TRI_VAL;
      CIRCLE:   v = CIR_VAL;
      default:  v = 0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy picker: largest in-stock coin whose value fits in the
// remaining change, in order Pentagon, Triangle, Circle.
module coin_select
  import change_pkg::*;
#(
  parameter int unsigned VALUE_W = 4,
  parameter int unsigned CNT_W   = 2
) (
  input  logic [VALUE_W-1:0] rem_i,
  input  logic [CNT_W-1:0]   pent_cnt_i,
  input  logic [CNT_W-1:0]   tri_cnt_i,
  input  logic [CNT_W-1:0]   cir_cnt_i,
  output coin_t              pick_o,
  output logic               found_o
);

  always_comb begin
    pick_o = NONE;
    if ((32'(rem_i) >= PENT_VAL) && (pent_cnt_i != '0)) begin
      pick_o = PENTAGON;
    end else if ((32'(rem_i) >= TRI_VAL) && (tri_cnt_i != '0)) begin
      pick_o = TRIANGLE;
    end else if ((32'(rem_i) >= CIR_VAL) && (cir_cnt_i != '0)) begin
      pick_o = CIRCLE;
    end
    found_o = (pick_o != NONE);
  end

endmodule

// File: rtl/change_dispenser.sv
// Sequential change-making engine: classifies a Cost/Paid transaction and, when
// change is owed, dispenses it greedily one coin per valid/ready handshake.
module change_dispenser
  import change_pkg::*;
#(
  parameter int unsigned VALUE_W    = 4,
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned MAX_COINS  = 2,
  parameter int unsigned INIT_COUNT = 3
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic               start,
  input  logic [VALUE_W-1:0] Cost,
  input  logic [VALUE_W-1:0] Paid,
  input  logic               restock,
  input  logic [1:0]         restock_coin,
  input  logic [CNT_W-1:0]   restock_count,
  output logic               coin_valid,
  output logic [1:0]         coin_type,
  input  logic               coin_ready,
  output logic               busy,
  output logic               done,
  output logic               ExactAmount,
  output logic               NotEnoughChange,
  output logic               CoughUpMore,
  output logic [VALUE_W-1:0] Remaining,
  output logic [CNT_W-1:0]   pent_count,
  output logic [CNT_W-1:0]   tri_count,
  output logic [CNT_W-1:0]   cir_count
);

  state_t             state_q, state_d;
  logic [VALUE_W-1:0] rem_q, rem_d;
  logic [VALUE_W-1:0] given_q, given_d;
  logic               less_q, less_d;
  logic               exact_q, exact_d;
  logic [CNT_W-1:0]   pent_q, pent_d;
  logic [CNT_W-1:0]   tri_q, tri_d;
  logic [CNT_W-1:0]   cir_q, cir_d;
  logic               res_exact_q, res_exact_d;
  logic               res_nec_q, res_nec_d;
  logic               res_cough_q, res_cough_d;
  logic [VALUE_W-1:0] res_rem_q, res_rem_d;

  coin_t              pick;
  logic               found;
  logic               offer;
  logic [VALUE_W-1:0] pick_val;
  logic [VALUE_W-1:0] rem_after;
  logic [VALUE_W-1:0] given_after;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  coin_select #(
    .VALUE_W (VALUE_W),
    .CNT_W   (CNT_W)
  ) u_coin_select (
    .rem_i      (rem_q),
    .pent_cnt_i (pent_q),
    .tri_cnt_i  (tri_q),
    .cir_cnt_i  (cir_q),
    .pick_o     (pick),
    .found_o    (found)
  );

  assign offer       = found && (given_q < VALUE_W'(MAX_COINS));
  assign pick_val    = VALUE_W'(coin_value(pick));
  assign rem_after   = rem_q - pick_val;
  assign given_after = given_q + VALUE_W'(1);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      given_q     <= '0;
      less_q      <= 1'b0;
      exact_q     <= 1'b0;
      pent_q      <= CNT_W'(INIT_COUNT);
      tri_q       <= CNT_W'(INIT_COUNT);
      cir_q       <= CNT_W'(INIT_COUNT);
      res_exact_q <= 1'b0;
      res_nec_q   <= 1'b0;
      res_cough_q <= 1'b0;
      res_rem_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      given_q     <= given_d;
      less_q      <= less_d;
      exact_q     <= exact_d;
      pent_q      <= pent_d;
      tri_q       <= tri_d;
      cir_q       <= cir_d;
      res_exact_q <= res_exact_d;
      res_nec_q   <= res_nec_d;
      res_cough_q <= res_cough_d;
      res_rem_q   <= res_rem_d;
    end
  end

  // Result registers load on the edge that enters DONE so they are valid with done.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    given_d     = given_q;
    less_d      = less_q;
    exact_d     = exact_q;
    pent_d      = pent_q;
    tri_d       = tri_q;
    cir_d       = cir_q;
    res_exact_d = res_exact_q;
    res_nec_d   = res_nec_q;
    res_cough_d = res_cough_q;
    res_rem_d   = res_rem_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          less_d  = (Paid < Cost);
          exact_d = (Paid == Cost);
          if (Paid > Cost) begin
            rem_d   = Paid - Cost;
            given_d = '0;
            state_d = S_DISPENSE;
          end else begin
            rem_d       = '0;
            state_d     = S_DONE;
            res_exact_d = (Paid == Cost);
            res_cough_d = (Paid < Cost);
            res_nec_d   = 1'b0;
            res_rem_d   = '0;
          end
        end else if (restock) begin
          unique case (coin_t'(restock_coin))
            PENTAGON: pent_d = sat_add(pent_q, restock_count);
            TRIANGLE: tri_d  = sat_add(tri_q, restock_count);
            CIRCLE:   cir_d  = sat_add(cir_q, restock_count);
            default:  ;
          endcase
        end
      end

      S_DISPENSE: begin
        if (!offer) begin
          state_d     = S_DONE;
          res_exact_d = exact_q;
          res_cough_d = less_q;
          res_rem_d   = rem_q;
          res_nec_d   = !less_q && !exact_q && (rem_q != '0);
        end else if (coin_ready) begin
          rem_d   = rem_after;
          given_d = given_after;
          unique case (pick)
            PENTAGON: pent_d = pent_q - CNT_W'(1);
            TRIANGLE: tri_d  = tri_q - CNT_W'(1);
            CIRCLE:   cir_d  = cir_q - CNT_W'(1);
            default:  ;
          endcase
          // Skip the extra check cycle when the handshake settles the transaction.
          if ((rem_after == '0) || (given_after >= VALUE_W'(MAX_COINS))) begin
            state_d     = S_DONE;
            res_exact_d = exact_q;
            res_cough_d = less_q;
            res_rem_d   = rem_after;
            res_nec_d   = !less_q && !exact_q && (rem_after != '0);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    coin_valid = (state_q == S_DISPENSE) && offer;
    coin_type  = coin_valid ? pick : NONE;
  end

  assign ExactAmount     = res_exact_q;
  assign NotEnoughChange = res_nec_q;
  assign CoughUpMore     = res_cough_q;
  assign Remaining       = res_rem_q;
  assign pent_count      = pent_q;
  assign tri_count       = tri_q;
  assign cir_count       = cir_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coins and results are queued
// when a transaction is driven and compared as the DUT offers coins and finishes.
module tb_change_dispenser;
  import change_pkg::*;

  localparam int unsigned MAXC = 2;

  logic       clock;
  logic       reset_L;
  logic       start;
  logic [3:0] Cost;
  logic [3:0] Paid;
  logic       restock;
  logic [1:0] restock_coin;
  logic [1:0] restock_count;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ready;
  logic       busy;
  logic       done;
  logic       ExactAmount;
  logic       NotEnoughChange;
  logic       CoughUpMore;
  logic [3:0] Remaining;
  logic [1:0] pent_count;
  logic [1:0] tri_count;
  logic [1:0] cir_count;

  typedef struct {
    logic       exact;
    logic       less;
    logic       nec;
    logic [3:0] rem;
  } res_t;

  coin_t exp_coin_q[$];
  res_t  exp_res_q[$];
  int    m_pent, m_tri, m_cir;
  int    n_checks = 0;
  int    n_fail   = 0;

  change_dispenser #(
    .VALUE_W    (4),
    .CNT_W      (2),
    .MAX_COINS  (MAXC),
    .INIT_COUNT (3)
  ) dut (
    .clock           (clock),
    .reset_L         (reset_L),
    .start           (start),
    .Cost            (Cost),
    .Paid            (Paid),
    .restock         (restock),
    .restock_coin    (restock_coin),
    .restock_count   (restock_count),
    .coin_valid      (coin_valid),
    .coin_type       (coin_type),
    .coin_ready      (coin_ready),
    .busy            (busy),
    .done            (done),
    .ExactAmount     (ExactAmount),
    .NotEnoughChange (NotEnoughChange),
    .CoughUpMore     (CoughUpMore),
    .Remaining       (Remaining),
    .pent_count      (pent_count),
    .tri_count       (tri_count),
    .cir_count       (cir_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int coin_val(input coin_t c);
    case (c)
      PENTAGON: return 5;
      TRIANGLE: return 3;
      CIRCLE:   return 1;
      default:  return 0;
    endcase
  endfunction

  function automatic coin_t greedy(input int rem, input int p, input int t, input int c);
    if (rem >= 5 && p > 0) return PENTAGON;
    if (rem >= 3 && t > 0) return TRIANGLE;
    if (rem >= 1 && c > 0) return CIRCLE;
    return NONE;
  endfunction

  task automatic check_counts(input string tag);
    check_eq({tag, "_pent"}, pent_count, m_pent);
    check_eq({tag, "_tri"},  tri_count,  m_tri);
    check_eq({tag, "_cir"},  cir_count,  m_cir);
  endtask

  task automatic do_restock(input coin_t c, input int amt);
    restock       = 1'b1;
    restock_coin  = c;
    restock_count = amt[1:0];
    case (c)
      PENTAGON: m_pent = (m_pent + amt > 3) ? 3 : m_pent + amt;
      TRIANGLE: m_tri  = (m_tri + amt > 3) ? 3 : m_tri + amt;
      CIRCLE:   m_cir  = (m_cir + amt > 3) ? 3 : m_cir + amt;
      default:  ;
    endcase
    @(posedge clock); #1;
    restock = 1'b0;
    check_counts("restock");
  endtask

  task automatic run_txn(input int cost, input int paid, input int stall, input bit try_restock);
    int    rem, given, tp, tt, tc, stall_left;
    bit    more, got_done;
    coin_t pk;
    res_t  r;
    more    = paid > cost;
    r.exact = (paid == cost);
    r.less  = (paid < cost);
    rem     = more ? paid - cost : 0;
    tp = m_pent; tt = m_tri; tc = m_cir;
    given = 0;
    if (more) begin
      while (given < MAXC) begin
        pk = greedy(rem, tp, tt, tc);
        if (pk == NONE) break;
        exp_coin_q.push_back(pk);
        case (pk)
          PENTAGON: tp--;
          TRIANGLE: tt--;
          default:  tc--;
        endcase
        rem -= coin_val(pk);
        given++;
      end
    end
    r.nec = more && (rem != 0);
    r.rem = rem[3:0];
    exp_res_q.push_back(r);

    start = 1'b1;
    Cost  = cost[3:0];
    Paid  = paid[3:0];
    @(posedge clock); #1;
    start = 1'b0;
    got_done   = 1'b0;
    stall_left = stall;
    for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
      check_counts("txn");
      if (cyc == 0 && !more) check_eq("quick_done", done, 1);
      if (cyc == 0 && more) check_eq("first_valid", coin_valid, exp_coin_q.size() != 0);
      if (try_restock && cyc == 0) begin
        restock       = 1'b1;
        restock_coin  = PENTAGON;
        restock_count = 2'd1;
      end else begin
        restock = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
        coin_ready = 1'b0;
        r = exp_res_q.pop_front();
        check_eq("ExactAmount",     ExactAmount,     r.exact);
        check_eq("CoughUpMore",     CoughUpMore,     r.less);
        check_eq("NotEnoughChange", NotEnoughChange, r.nec);
        check_eq("Remaining",       Remaining,       r.rem);
        check_eq("coins_left",      exp_coin_q.size(), 0);
        check_eq("done_no_valid",   coin_valid,      0);
      end else if (coin_valid) begin
        if (exp_coin_q.size() == 0) begin
          check_eq("extra_coin", coin_type, NONE);
          coin_ready = 1'b1;
        end else begin
          check_eq("coin_type", coin_type, exp_coin_q[0]);
          if (stall_left > 0) begin
            coin_ready = 1'b0;
            stall_left--;
          end else begin
            coin_ready = 1'b1;
            pk = exp_coin_q.pop_front();
            case (pk)
              PENTAGON: m_pent--;
              TRIANGLE: m_tri--;
              default:  m_cir--;
            endcase
          end
        end
      end else begin
        coin_ready = 1'b0;
        check_eq("idle_type", coin_type, NONE);
      end
      @(posedge clock); #1;
    end
    restock    = 1'b0;
    coin_ready = 1'b0;
    if (!got_done) check_eq("done_timeout", done, 1);
    check_eq("after_busy", busy, 0);
    exp_coin_q.delete();
    exp_res_q.delete();
  endtask

  initial begin
    clock = 1'b0; reset_L = 1'b1; start = 1'b0; Cost = '0; Paid = '0;
    restock = 1'b0; restock_coin = '0; restock_count = '0; coin_ready = 1'b0;
    m_pent = 3; m_tri = 3; m_cir = 3;
    #1 reset_L = 1'b0;
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_valid", coin_valid, 0);
    check_eq("rst_type", coin_type, NONE);
    check_eq("rst_exact", ExactAmount, 0);
    check_eq("rst_nec", NotEnoughChange, 0);
    check_eq("rst_cough", CoughUpMore, 0);
    check_eq("rst_rem", Remaining, 0);
    check_counts("rst");
    @(posedge clock); #1;
    reset_L = 1'b1;
    @(posedge clock); #1;

    run_txn(5, 5, 0, 0);
    run_txn(9, 4, 0, 0);
    run_txn(2, 10, 0, 0);
    do_restock(PENTAGON, 3);
    do_restock(TRIANGLE, 1);
    do_restock(NONE, 3);
    run_txn(1, 13, 5, 1);
    do_restock(PENTAGON, 2);
    run_txn(0, 15, 0, 0);
    run_txn(4, 7, 0, 0);
    run_txn(14, 15, 0, 0);
    do_restock(PENTAGON, 3);
    run_txn(5, 0, 0, 0);

    start = 1'b1; Cost = 4'd1; Paid = 4'd13;
    @(posedge clock); #1;
    start = 1'b0;
    check_eq("abort_valid", coin_valid, 1);
    check_eq("abort_type", coin_type, PENTAGON);
    coin_ready = 1'b1;
    @(posedge clock); #1;
    coin_ready = 1'b0;
    check_eq("abort_pent", pent_count, m_pent - 1);
    check_eq("abort_busy", busy, 1);
    reset_L = 1'b0;
    #2;
    m_pent = 3; m_tri = 3; m_cir = 3;
    check_eq("abort_rst_busy", busy, 0);
    check_eq("abort_rst_valid", coin_valid, 0);
    check_eq("abort_rst_type", coin_type, NONE);
    check_eq("abort_rst_done", done, 0);
    check_counts("abort_rst");
    @(posedge clock); #1;
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("abort_no_done", done, 0);
      @(posedge clock); #1;
    end

    run_txn(2, 10, 0, 0);
    check_counts("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequential, parametrised change-making engine for the vending datapath. It accepts one Cost/Paid transaction at a time and classifies it as less, exact or more. For "more", it dispenses change greedily, one coin per valid/ready handshake, from internally tracked Pentagon (5), Triangle (3) and Circle (1) inventories, then reports the residual shortfall. It sits between the payment front end and the coin-ejector mechanism.

## Interface
Parameters:
- VALUE_W, default 4: width of Cost, Paid, Remaining and internal change.
- CNT_W, default 2: width of each coin inventory counter.
- MAX_COINS, default 2: maximum coins dispensed per transaction; range 1..2^VALUE_W-1.
- INIT_COUNT, default 3: inventory value of every coin type after reset; must be at most 2^CNT_W-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- start  in  1  transaction request; sampled only in IDLE.
- Cost  in  VALUE_W  item cost, sampled with start.
- Paid  in  VALUE_W  amount paid, sampled with start.
- restock  in  1  inventory add request; sampled only in IDLE when start=0.
- restock_coin  in  2  coin_t selecting the coin to restock.
- restock_count  in  CNT_W  amount to add.
- coin_valid  out  1  a coin is offered on coin_type.
- coin_type  out  2  coin_t of the offered coin; NONE when coin_valid=0.
- coin_ready  in  1  ejector accepts the offered coin.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse; result outputs are valid in this cycle.
- ExactAmount, NotEnoughChange, CoughUpMore  out  1 each  registered transaction result flags.
- Remaining  out  VALUE_W  change still owed after dispensing.
- pent_count, tri_count, cir_count  out  CNT_W each  current inventory.

## Operation
- FSM states: IDLE, DISPENSE, DONE.
- IDLE + start:
  - Latch Paid<Cost into less and Paid==Cost into exact.
  - If Paid>Cost: rem <= Paid-Cost and given <= 0, then go to DISPENSE.
  - Otherwise rem <= 0, then go to DONE.
  - The subtraction is performed only when Paid>Cost, so it never wraps.
- DISPENSE:
  - Pick the largest coin with value<=rem and count>0, in order Pentagon, Triangle, Circle.
  - If a coin is picked and given<MAX_COINS: coin_valid=1 and coin_type=pick.
  - Otherwise go to DONE with coin_valid=0.
  - On coin_valid&coin_ready: rem -= value, the selected count decrements, given increments.
  - Dispensed coins are committed and never returned.
- DONE:
  - done=1 and ExactAmount=exact.
  - CoughUpMore=less.
  - Remaining=rem, and NotEnoughChange=(rem!=0) for "more" transactions, 0 otherwise.
  - Return to IDLE next cycle.
- Result outputs hold their last values until the next DONE.
- start outside IDLE is ignored.
- restock is ignored outside IDLE and whenever start=1.
- Restock add saturates at 2^CNT_W-1.
- restock_coin=NONE is a no-op.

## Timing
- Reset values:
  - state=IDLE.
  - All flags, done, busy and coin_valid are 0.
  - coin_type=NONE and Remaining=0.
  - All inventory counts=INIT_COUNT.
- Reset asserted mid-transaction aborts it; no done pulse is produced. The inventory returns to INIT_COUNT.
- Less/exact transaction: start is sampled at edge N, and done is high in cycle N+1.
- More transaction:
  - The first coin_valid appears in cycle N+1.
  - Each handshake edge exposes the next selection in the following cycle.
  - done is high one cycle after the final handshake, or one cycle after the no-coin/limit check.
- Backpressure: while coin_valid=1 and coin_ready=0, coin_type is held stable. coin_ready while coin_valid=0 has no effect.
- Outputs are derived from registers only; there is no combinational input-to-output path except none required.

## Structure
- Package change_pkg holds:
  - coin_t enum: NONE=0, CIRCLE=1, TRIANGLE=2, PENTAGON=3.
  - Coin value constants 1/3/5.
  - state_t enum.
  - A coin_value(coin_t) function.
- Sub-module coin_select: combinational greedy picker. Inputs are rem and the three counts; outputs are the picked coin_t and a found flag.

## Test plan
- Cost=5, Paid=5 -> done in the cycle after start, ExactAmount=1, no coin_valid, Remaining=0.
- Cost=9, Paid=4 -> CoughUpMore=1, no coins, inventory unchanged.
- Counts 3/3/3, Cost=2, Paid=10, coin_ready=1 -> PENTAGON then TRIANGLE, Remaining=0, NotEnoughChange=0, counts 2/2/3.
- MAX_COINS=2, Cost=1, Paid=13 -> PENTAGON, PENTAGON, Remaining=2, NotEnoughChange=1.
- coin_ready held at 0 for 5 cycles mid-dispense -> coin_type stable and counts unchanged until the handshake.
- Restock:
  - PENTAGON +3 onto a count of 2 -> saturates to 3.
  - restock during busy -> ignored.
- Reset asserted during DISPENSE -> IDLE, counts=3, no done pulse.
